sha_uart_ctrl: RTL and testbench

SHA_UART_CTRL -- requirements
Module: sha_uart_ctrl

---
 rtl/sha_uart_ctrl.sv | 175 +++++++++++++++++
 tb/tb_sha_uart_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_uart_ctrl.sv
// -----------------------------------------------------------------------------
// sha_uart_ctrl
//   Collects bytes from a UART receiver into a single SHA-256 block, pads it
//   once a terminator byte arrives, launches the hash core, latches the digest
//   and hands it to the UART transmitter. Messages longer than 55 bytes do not
//   fit a single padded block; they raise Err and are dropped up to the next
//   terminator.
//
// Ports
//   Clk         system clock, rising edge
//   Reset       asynchronous active-low reset
//   RxData      received byte, qualified by RxValid
//   RxValid     one-cycle strobe for RxData
//   Block       padded 512-bit block, byte 0 at [511:504]
//   HashStart   one-cycle pulse to start the hash core
//   HashDone    hash-complete indication from the core
//   HashDigest  digest from the core, valid while HashDone is high
//   TxStart     one-cycle pulse to start transmitting Digest
//   Digest      latched digest presented to the transmitter
//   TxDone      transmitter-finished indication
//   Busy        high whenever the block is not accepting bytes
//   Err         one-cycle pulse on message overflow
// -----------------------------------------------------------------------------
module sha_uart_ctrl #(
   parameter logic [7:0] TERM1 = 8'h0D,
   parameter logic [7:0] TERM2 = 8'h0A
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [7:0]   RxData,
   input  logic         RxValid,
   output logic [511:0] Block,
   output logic         HashStart,
   input  logic         HashDone,
   input  logic [255:0] HashDigest,
   output logic         TxStart,
   output logic [255:0] Digest,
   input  logic         TxDone,
   output logic         Busy,
   output logic         Err
);

   typedef enum logic [2:0] {
      StRecv,
      StDiscard,
      StPad,
      StHashStart,
      StHashWait,
      StTxStart,
      StTxWait
   } state_e;

   // Largest message that still leaves room for the 0x80 marker and the
   // 64-bit length field in one block.
   localparam logic [5:0] MaxCnt = 6'd55;

   state_e         state_q, state_d;
   logic [5:0]     cnt_q, cnt_d;
   logic [511:0]   block_q, block_d;
   logic [255:0]   digest_q, digest_d;
   logic           hash_start_q, hash_start_d;
   logic           tx_start_q, tx_start_d;
   logic           err_q, err_d;
   logic           is_term;
   logic [8:0]     byte_msb;

   assign is_term = (RxData == TERM1) || (RxData == TERM2);

   // MSB of byte cnt within the block: 511 - 8*cnt, which for a 9-bit
   // operand is simply its bitwise complement.
   assign byte_msb = {~cnt_q, 3'b111};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      block_d      = block_q;
      digest_d     = digest_q;
      hash_start_d = 1'b0;
      tx_start_d   = 1'b0;
      err_d        = 1'b0;

      unique case (state_q)
         StRecv: begin
            if (RxValid) begin
               if (is_term) begin
                  // An empty message (e.g. the LF of a CR LF pair) is ignored.
                  if (cnt_q != 6'd0) begin
                     state_d = StPad;
                  end
               end else if (cnt_q == MaxCnt) begin
                  err_d   = 1'b1;
                  cnt_d   = 6'd0;
                  block_d = '0;
                  state_d = StDiscard;
               end else begin
                  block_d[byte_msb -: 8] = RxData;
                  cnt_d                  = cnt_q + 6'd1;
               end
            end
         end

         StDiscard: begin
            if (RxValid && is_term) begin
               cnt_d   = 6'd0;
               state_d = StRecv;
            end
         end

         StPad: begin
            // Bytes past the marker are already zero: the block is cleared
            // whenever a message is finished or dropped.
            block_d[byte_msb -: 8] = 8'h80;
            block_d[63:0]          = {55'd0, cnt_q, 3'b000};
            hash_start_d           = 1'b1;
            state_d                = StHashStart;
         end

         StHashStart: begin
            state_d = StHashWait;
         end

         StHashWait: begin
            if (HashDone) begin
               digest_d   = HashDigest;
               tx_start_d = 1'b1;
               state_d    = StTxStart;
            end
         end

         StTxStart: begin
            state_d = StTxWait;
         end

         StTxWait: begin
            if (TxDone) begin
               block_d = '0;
               cnt_d   = 6'd0;
               state_d = StRecv;
            end
         end

         default: begin
            state_d = StRecv;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= StRecv;
         cnt_q        <= 6'd0;
         block_q      <= '0;
         digest_q     <= '0;
         hash_start_q <= 1'b0;
         tx_start_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         block_q      <= block_d;
         digest_q     <= digest_d;
         hash_start_q <= hash_start_d;
         tx_start_q   <= tx_start_d;
         err_q        <= err_d;
      end
   end

   assign Block     = block_q;
   assign Digest    = digest_q;
   assign HashStart = hash_start_q;
   assign TxStart   = tx_start_q;
   assign Err       = err_q;
   assign Busy      = (state_q != StRecv) && (state_q != StDiscard);

endmodule

// File: tb/tb_sha_uart_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sha_uart_ctrl
//   Self-checking bench for sha_uart_ctrl. Expected blocks are queued when a
//   terminator is driven and compared by a monitor on each HashStart pulse.
//   Main thread runs at posedge+1 phase; reset is applied on negedges.
// -----------------------------------------------------------------------------
module tb_sha_uart_ctrl;

   logic         Clk;
   logic         Reset;
   logic [7:0]   RxData;
   logic         RxValid;
   logic [511:0] Block;
   logic         HashStart;
   logic         HashDone;
   logic [255:0] HashDigest;
   logic         TxStart;
   logic [255:0] Digest;
   logic         TxDone;
   logic         Busy;
   logic         Err;

   sha_uart_ctrl dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .RxData     (RxData),
      .RxValid    (RxValid),
      .Block      (Block),
      .HashStart  (HashStart),
      .HashDone   (HashDone),
      .HashDigest (HashDigest),
      .TxStart    (TxStart),
      .Digest     (Digest),
      .TxDone     (TxDone),
      .Busy       (Busy),
      .Err        (Err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [63:0]  msg;
      int unsigned  len;
      logic [7:0]   term;
      logic [511:0] blk;
      logic [255:0] dig;
   } vec_t;

   localparam logic [255:0] AbcDigest =
      256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD;
   localparam logic [511:0] AbcBlock = {32'h61626380, 416'd0, 64'h18};

   int checks = 0;
   int errors = 0;
   int n_hs   = 0;
   int n_tx   = 0;
   int n_err  = 0;
   int exp_hs = 0;
   int exp_tx = 0;
   logic [511:0] exp_q [$];
   vec_t vecs [4];

   task automatic chk_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every HashStart must match the oldest queued block.
   always @(posedge Clk) begin
      #1;
      if (HashStart === 1'b1) begin
         n_hs++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_hashstart: got pulse expected none");
         end else begin
            chk_vec("block_at_hashstart", Block, exp_q.pop_front());
         end
      end
      if (TxStart === 1'b1) n_tx++;
      if (Err === 1'b1) n_err++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      RxData  = b;
      RxValid = 1'b1;
      @(posedge Clk);
      #1;
      RxValid = 1'b0;
   endtask

   // Terminator accepted at edge N: PAD after N, HashStart high after N+1
   // (sampled by the core at N+2), gone after N+2.
   task automatic term_and_check(input logic [7:0] term, input logic [511:0] blk);
      exp_q.push_back(blk);
      exp_hs++;
      send_byte(term);
      chk_bit("hashstart_n", HashStart, 1'b0);
      chk_bit("busy_pad", Busy, 1'b1);
      tick(1);
      chk_bit("hashstart_n1", HashStart, 1'b1);
      tick(1);
      chk_bit("hashstart_n2", HashStart, 1'b0);
   endtask

   task automatic finish_hash(input logic [255:0] d);
      tick(2);
      // TxDone outside TX_WAIT must not matter.
      TxDone = 1'b1;
      tick(1);
      TxDone = 1'b0;
      chk_bit("busy_hash_wait", Busy, 1'b1);
      chk_bit("txstart_idle", TxStart, 1'b0);
      HashDigest = d;
      HashDone   = 1'b1;
      tick(1);
      HashDone   = 1'b0;
      HashDigest = '0;
      exp_tx++;
      chk_bit("txstart_pulse", TxStart, 1'b1);
      chk_vec("digest_latched", {256'd0, Digest}, {256'd0, d});
      tick(1);
      chk_bit("txstart_off", TxStart, 1'b0);
      tick(2);
      chk_bit("busy_tx_wait", Busy, 1'b1);
      TxDone = 1'b1;
      tick(1);
      TxDone = 1'b0;
      chk_bit("busy_after_txdone", Busy, 1'b0);
      chk_vec("block_cleared", Block, 512'd0);
   endtask

   task automatic run_vec(input vec_t v);
      for (int i = 0; i < int'(v.len); i++) begin
         send_byte(v.msg[63 - 8 * i -: 8]);
      end
      term_and_check(v.term, v.blk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk_vec({tag, "_block"}, Block, 512'd0);
      chk_vec({tag, "_digest"}, {256'd0, Digest}, 512'd0);
      chk_bit({tag, "_hashstart"}, HashStart, 1'b0);
      chk_bit({tag, "_txstart"}, TxStart, 1'b0);
      chk_bit({tag, "_err"}, Err, 1'b0);
      chk_bit({tag, "_busy"}, Busy, 1'b0);
   endtask

   initial begin
      logic [511:0] big_blk;
      int           hs_before;
      int           err_before;

      vecs[0] = '{msg: {24'h616263, 40'd0}, len: 3, term: 8'h0D,
                  blk: AbcBlock, dig: AbcDigest};
      vecs[1] = '{msg: {8'h61, 56'd0}, len: 1, term: 8'h0A,
                  blk: {16'h6180, 432'd0, 64'h8}, dig: {8{32'h0123ABCD}}};
      vecs[2] = '{msg: {16'h4869, 48'd0}, len: 2, term: 8'h0D,
                  blk: {24'h486980, 424'd0, 64'h10}, dig: {8{32'hDEADBEEF}}};
      vecs[3] = '{msg: 64'h3031323334353637, len: 8, term: 8'h0A,
                  blk: {72'h303132333435363780, 376'd0, 64'h40}, dig: {4{64'hA5A5_0F0F_1234_5678}}};

      Reset      = 1'b0;
      RxData     = 8'h00;
      RxValid    = 1'b0;
      HashDone   = 1'b0;
      HashDigest = '0;
      TxDone     = 1'b0;
      #1;
      check_reset_outputs("reset");
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1;

      // Table-driven messages.
      for (int i = 0; i < 4; i++) begin
         run_vec(vecs[i]);
         finish_hash(vecs[i].dig);
      end

      // "a",CR,LF back to back: LF lands in PAD and is dropped.
      send_byte(8'h61);
      exp_q.push_back({16'h6180, 432'd0, 64'h8});
      exp_hs++;
      send_byte(8'h0D);
      send_byte(8'h0A);
      tick(1);
      finish_hash(256'h1);
      // Lone terminator in RECV with cnt==0 is ignored.
      hs_before = n_hs;
      send_byte(8'h0A);
      send_byte(8'h0D);
      tick(3);
      chk_vec("lone_term_no_hash", 512'(n_hs), 512'(hs_before));
      chk_bit("lone_term_busy", Busy, 1'b0);

      // 55 bytes fill the block exactly.
      big_blk = '0;
      for (int i = 0; i < 55; i++) begin
         logic [7:0] b;
         b = 8'(8'h40 + i);
         big_blk[511 - 8 * i -: 8] = b;
         send_byte(b);
      end
      chk_bit("err_55", Err, 1'b0);
      big_blk[71:64] = 8'h80;
      big_blk[63:0]  = 64'h1B8;
      term_and_check(8'h0D, big_blk);
      chk_vec("len_field_55", {448'd0, Block[63:0]}, 512'h1B8);
      chk_vec("marker_55", {504'd0, Block[71:64]}, 512'h80);
      finish_hash(256'h55);

      // 56 bytes overflow: Err pulse, rest discarded up to terminator.
      err_before = n_err;
      hs_before  = n_hs;
      for (int i = 0; i < 56; i++) send_byte(8'(8'h20 + i));
      chk_bit("err_pulse", Err, 1'b1);
      chk_bit("busy_discard", Busy, 1'b0);
      chk_vec("block_overflow_cleared", Block, 512'd0);
      send_byte(8'h78);
      chk_bit("err_one_cycle", Err, 1'b0);
      send_byte(8'h79);
      send_byte(8'h0D);
      tick(3);
      chk_vec("overflow_no_hash", 512'(n_hs), 512'(hs_before));
      chk_vec("overflow_err_count", 512'(n_err), 512'(err_before + 1));
      chk_vec("discard_block_zero", Block, 512'd0);
      run_vec(vecs[0]);
      finish_hash(AbcDigest);

      // Bytes during HASH_WAIT are dropped.
      run_vec(vecs[0]);
      send_byte(8'h7A);
      send_byte(8'h7A);
      chk_vec("block_stable_hash_wait", Block, AbcBlock);
      finish_hash(AbcDigest);
      run_vec(vecs[2]);
      finish_hash(vecs[2].dig);

      // Reset mid-hash, then stray HashDone/TxDone in RECV, then recovery.
      run_vec(vecs[0]);
      tick(1);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      check_reset_outputs("midhash_reset");
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      HashDigest = {8{32'hFFFF0000}};
      HashDone   = 1'b1;
      TxDone     = 1'b1;
      tick(2);
      HashDone   = 1'b0;
      TxDone     = 1'b0;
      HashDigest = '0;
      chk_vec("stray_hashdone_digest", {256'd0, Digest}, 512'd0);
      chk_bit("stray_hashdone_busy", Busy, 1'b0);
      run_vec(vecs[0]);
      finish_hash(AbcDigest);

      tick(2);
      chk_vec("total_hashstarts", 512'(n_hs), 512'(exp_hs));
      chk_vec("total_txstarts", 512'(n_tx), 512'(exp_tx));
      chk_vec("scoreboard_empty", 512'(exp_q.size()), 512'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
